// File: rtl/net_router_pkg.sv
// -----------------------------------------------------------------------------
// net_router_pkg
// Shared definitions for the router port controllers and the network
// interface unit.
//   NET_MAX_REQS  : widest request vector any controller may use
//   rr_prio_mask  : round-robin priority mask (bits at/above the pointer)
//   rr_pick       : one-hot round-robin winner built on rr_prio_mask
//   onehot_to_bin : one-hot to binary index encoder
// -----------------------------------------------------------------------------
package net_router_pkg;

    localparam int NET_MAX_REQS  = 8;
    localparam int NET_IDX_NBITS = 3;

    typedef logic [NET_MAX_REQS-1:0]  net_req_vec_t;
    typedef logic [NET_IDX_NBITS-1:0] net_idx_t;

    // Requests at or above the pointer win before the search wraps to index 0.
    function automatic net_req_vec_t rr_prio_mask(input net_idx_t ptr);
        return {NET_MAX_REQS{1'b1}} << ptr;
    endfunction

    // Isolate the lowest set bit (two's-complement trick).
    function automatic net_req_vec_t lowest_set(input net_req_vec_t v);
        return v & (~v + net_req_vec_t'(1));
    endfunction

    // One-hot round-robin winner; zero when no request is present.
    function automatic net_req_vec_t rr_pick(input net_req_vec_t reqs,
                                             input net_idx_t     ptr);
        net_req_vec_t masked;
        masked = reqs & rr_prio_mask(ptr);
        return (masked != '0) ? lowest_set(masked) : lowest_set(reqs);
    endfunction

    function automatic net_idx_t onehot_to_bin(input net_req_vec_t oh);
        net_idx_t idx;
        idx = '0;
        for (int i = 0; i < NET_MAX_REQS; i++) begin
            if (oh[i]) idx = idx | net_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/net_credit_counter.sv
// -----------------------------------------------------------------------------
// net_credit_counter
// Tracks free slots in the downstream buffer. Starts full, decrements on each
// flit sent, increments on each returned credit, saturates at full.
//   clk        : clock
//   reset      : asynchronous active-low reset (counter reloads to full)
//   dec        : one flit sent this cycle
//   inc        : one credit returned this cycle
//   clr        : synchronous reload to full
//   has_credit : at least one downstream slot is free (always 1 when p_en=0)
// -----------------------------------------------------------------------------
module net_credit_counter
    import net_router_pkg::*;
#(
    parameter int p_num_credits = 4,
    parameter bit p_en          = 1'b1
)(
    input  logic clk,
    input  logic reset,
    input  logic dec,
    input  logic inc,
    input  logic clr,
    output logic has_credit
);

    localparam int         CNT_NBITS = 4;
    localparam logic [3:0] CNT_FULL  = CNT_NBITS'(p_num_credits);

    generate
        if (p_en) begin : g_cnt
            logic [CNT_NBITS-1:0] r_credits;

            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values regardless of block evaluation order.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_credits <= CNT_FULL;
                end else if (clr) begin
                    r_credits <= CNT_FULL;
                end else if (dec && !inc) begin
                    r_credits <= r_credits - 4'd1;
                end else if (inc && !dec && (r_credits != CNT_FULL)) begin
                    // A return while already full is dropped.
                    r_credits <= r_credits + 4'd1;
                end
            end

            assign has_credit = (r_credits != '0);
        end else begin : g_no_cnt
            logic w_unused;
            assign w_unused   = ^{clk, reset, dec, inc, clr};
            assign has_credit = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/net_router_output_ctrl_wh.sv
// -----------------------------------------------------------------------------
// net_router_output_ctrl_wh
// Wormhole output-port controller: round-robin arbitration across input
// queues, grant held from head flit to tail flit, optional credit flow
// control, and arbitration flush on a security-domain change.
//   clk        : clock
//   reset      : asynchronous active-low reset
//   out_domain : security domain currently owning this output
//   reqs       : per-input head-of-queue valid
//   reqs_tail  : per-input head flit is the packet tail
//   grants     : one-hot dequeue strobe (already qualified by can_send)
//   out_val    : flit valid toward downstream
//   out_rdy    : downstream ready
//   credit_ret : downstream returned one credit
//   xbar_sel   : binary index of the granted input (holds when idle)
//   err_trunc  : one-cycle pulse when a domain change broke a packet lock
// -----------------------------------------------------------------------------
module net_router_output_ctrl_wh
    import net_router_pkg::*;
#(
    parameter int p_num_reqs    = 3,
    parameter int p_sel_nbits   = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1,
    parameter int p_credit_en   = 1,
    parameter int p_num_credits = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   out_domain,
    input  logic [p_num_reqs-1:0]  reqs,
    input  logic [p_num_reqs-1:0]  reqs_tail,
    output logic [p_num_reqs-1:0]  grants,
    output logic                   out_val,
    input  logic                   out_rdy,
    input  logic                   credit_ret,
    output logic [p_sel_nbits-1:0] xbar_sel,
    output logic                   err_trunc
);

    localparam logic [p_num_reqs-1:0]  REQ_ONE  = p_num_reqs'(1);
    localparam logic [p_sel_nbits-1:0] IDX_ONE  = p_sel_nbits'(1);
    localparam logic [p_sel_nbits-1:0] IDX_LAST = p_sel_nbits'(p_num_reqs - 1);

    logic [p_sel_nbits-1:0] r_prio_ptr;
    logic [p_sel_nbits-1:0] r_lock_idx;
    logic [p_sel_nbits-1:0] r_last_sel;
    logic                   r_lock;
    logic                   r_dom_q;
    logic                   r_dom_valid;
    logic                   r_err_trunc;

    logic                   w_has_credit;
    logic                   w_can_send;
    logic                   w_dom_chg;
    logic                   w_fire;
    logic                   w_tail_fire;
    logic [p_num_reqs-1:0]  w_lock_oh;
    logic [p_num_reqs-1:0]  w_rr_oh;
    logic [p_num_reqs-1:0]  w_grants;
    net_req_vec_t           w_rr_full;
    net_idx_t               w_sel_full;
    logic [p_sel_nbits-1:0] w_sel;
    logic [p_sel_nbits-1:0] w_ptr_next;
    logic                   w_unused;

    net_credit_counter #(
        .p_num_credits (p_num_credits),
        .p_en          (p_credit_en != 0)
    ) u_credits (
        .clk        (clk),
        .reset      (reset),
        .dec        (w_fire),
        .inc        (credit_ret),
        .clr        (w_dom_chg),
        .has_credit (w_has_credit)
    );

    assign w_can_send = out_rdy && w_has_credit;

    // r_dom_valid is low for the first cycle after reset release; dom_q is
    // loaded from out_domain at that edge, so no change is seen on release.
    assign w_dom_chg = r_dom_valid && (out_domain != r_dom_q);

    assign w_rr_full = rr_pick(net_req_vec_t'(reqs), net_idx_t'(r_prio_ptr));
    assign w_rr_oh   = w_rr_full[p_num_reqs-1:0];
    assign w_lock_oh = REQ_ONE << r_lock_idx;

    // NOTE: assign a default before any branch so the combinational block can
    // never hold a value and infer a latch.
    always_comb begin
        w_grants = '0;
        if (reset && w_can_send && !w_dom_chg) begin
            // While locked only the owner may move; its missing req is a bubble.
            w_grants = r_lock ? (w_lock_oh & reqs) : w_rr_oh;
        end
    end

    assign w_fire      = |w_grants;
    assign w_tail_fire = |(w_grants & reqs_tail);
    assign w_sel_full  = onehot_to_bin(net_req_vec_t'(w_grants));
    assign w_sel       = w_sel_full[p_sel_nbits-1:0];
    assign w_ptr_next  = (w_sel == IDX_LAST) ? '0 : (w_sel + IDX_ONE);
    assign w_unused    = ^{w_rr_full, w_sel_full};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio_ptr  <= '0;
            r_lock      <= 1'b0;
            r_lock_idx  <= '0;
            r_last_sel  <= '0;
            r_dom_q     <= 1'b0;
            r_dom_valid <= 1'b0;
            r_err_trunc <= 1'b0;
        end else begin
            r_dom_q     <= out_domain;
            r_dom_valid <= 1'b1;
            r_err_trunc <= w_dom_chg && r_lock;
            if (w_dom_chg) begin
                // Drop all priority history so nothing leaks across domains.
                r_prio_ptr <= '0;
                r_lock     <= 1'b0;
            end else if (w_fire) begin
                r_last_sel <= w_sel;
                if (w_tail_fire) begin
                    r_lock     <= 1'b0;
                    r_prio_ptr <= w_ptr_next;
                end else begin
                    r_lock     <= 1'b1;
                    r_lock_idx <= w_sel;
                end
            end
        end
    end

    assign grants    = w_grants;
    assign out_val   = w_fire;
    assign xbar_sel  = w_fire ? w_sel : r_last_sel;
    assign err_trunc = r_err_trunc;

endmodule

// File: tb/tb_net_router_output_ctrl_wh.sv
// -----------------------------------------------------------------------------
// tb_net_router_output_ctrl_wh
// Two controllers share one stimulus stream: dut0 (3 inputs, 2 credits) and
// dut1 (5 inputs, no credit flow control). A behavioural model predicts each
// cycle's outputs; expectations are queued by the stimulus process and popped
// by an independent monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_net_router_output_ctrl_wh;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       out_domain = 1'b0;
    logic       out_rdy    = 1'b0;
    logic       credit_ret = 1'b0;
    logic [7:0] reqs8      = '0;
    logic [7:0] tails8     = '0;

    logic [2:0] g0;
    logic       v0;
    logic [1:0] s0;
    logic       e0;
    logic [4:0] g1;
    logic       v1;
    logic [2:0] s1;
    logic       e1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    net_router_output_ctrl_wh #(
        .p_num_reqs (3), .p_credit_en (1), .p_num_credits (2)
    ) dut0 (
        .clk (clk), .reset (reset), .out_domain (out_domain),
        .reqs (reqs8[2:0]), .reqs_tail (tails8[2:0]), .grants (g0),
        .out_val (v0), .out_rdy (out_rdy), .credit_ret (credit_ret),
        .xbar_sel (s0), .err_trunc (e0)
    );

    net_router_output_ctrl_wh #(
        .p_num_reqs (5), .p_credit_en (0), .p_num_credits (4)
    ) dut1 (
        .clk (clk), .reset (reset), .out_domain (out_domain),
        .reqs (reqs8[4:0]), .reqs_tail (tails8[4:0]), .grants (g1),
        .out_val (v1), .out_rdy (out_rdy), .credit_ret (credit_ret),
        .xbar_sel (s1), .err_trunc (e1)
    );

    // ---------------- behavioural model ----------------
    int m_n[2]     = '{3, 5};
    int m_cen[2]   = '{1, 0};
    int m_ncred[2] = '{2, 4};
    int m_ptr[2];
    int m_lock[2];
    int m_lidx[2];
    int m_cred[2];
    int m_dom[2];   // -1: not yet sampled since reset
    int m_err[2];
    int m_last[2];

    typedef struct packed {
        logic [7:0] gr;
        logic       val;
        logic [2:0] sel;
        logic       err;
    } exp_t;

    exp_t sb_q0[$];
    exp_t sb_q1[$];

    function automatic void model_reset(input int k);
        m_ptr[k]  = 0;
        m_lock[k] = 0;
        m_lidx[k] = 0;
        m_cred[k] = m_ncred[k];
        m_dom[k]  = -1;
        m_err[k]  = 0;
        m_last[k] = 0;
    endfunction

    function automatic bit model_dom_chg(input int k);
        return (m_dom[k] >= 0) && (m_dom[k] != int'(out_domain));
    endfunction

    // Index granted this cycle from the present inputs, or -1.
    function automatic int model_grant(input int k);
        if (!reset) return -1;
        if (model_dom_chg(k)) return -1;
        if (!out_rdy) return -1;
        if (m_cen[k] != 0 && m_cred[k] == 0) return -1;
        if (m_lock[k] != 0) return reqs8[m_lidx[k]] ? m_lidx[k] : -1;
        for (int i = 0; i < m_n[k]; i++) begin
            int j;
            j = (m_ptr[k] + i) % m_n[k];
            if (reqs8[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_edge(input int k);
        int  g;
        bit  chg;
        if (!reset) begin
            model_reset(k);
            return;
        end
        g   = model_grant(k);
        chg = model_dom_chg(k);
        m_err[k] = (chg && m_lock[k] != 0) ? 1 : 0;
        if (chg) begin
            m_ptr[k]  = 0;
            m_lock[k] = 0;
            m_cred[k] = m_ncred[k];
        end else begin
            if (g >= 0) begin
                m_last[k] = g;
                if (tails8[g]) begin
                    m_lock[k] = 0;
                    m_ptr[k]  = (g + 1) % m_n[k];
                end else begin
                    m_lock[k] = 1;
                    m_lidx[k] = g;
                end
            end
            if (m_cen[k] != 0) begin
                m_cred[k] = m_cred[k] - ((g >= 0) ? 1 : 0) + (credit_ret ? 1 : 0);
                if (m_cred[k] > m_ncred[k]) m_cred[k] = m_ncred[k];
            end
        end
        m_dom[k] = int'(out_domain);
    endfunction

    function automatic exp_t model_expect(input int k);
        exp_t e;
        int   g;
        g     = model_grant(k);
        e.gr  = (g >= 0) ? (8'b1 << g) : 8'b0;
        e.val = (g >= 0);
        e.sel = (g >= 0) ? 3'(g) : 3'(m_last[k]);
        e.err = (m_err[k] != 0);
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q0.size() > 0) begin
                e = sb_q0.pop_front();
                check("d0_grants",  32'(g0), 32'(e.gr));
                check("d0_out_val", 32'(v0), 32'(e.val));
                check("d0_xbar",    32'(s0), 32'(e.sel));
                check("d0_err",     32'(e0), 32'(e.err));
            end
            if (sb_q1.size() > 0) begin
                e = sb_q1.pop_front();
                check("d1_grants",  32'(g1), 32'(e.gr));
                check("d1_out_val", 32'(v1), 32'(e.val));
                check("d1_xbar",    32'(s1), 32'(e.sel));
                check("d1_err",     32'(e1), 32'(e.err));
            end
        end
    end

    // ---------------- stimulus ----------------
    // rst_mode: 0 = reset released/high, 1 = drop reset mid-cycle, 2 = hold low
    task automatic step(input logic [7:0] rq, input logic [7:0] tl, input logic rdy,
                        input logic ret, input logic dom, input int rst_mode);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        reqs8      = rq;
        tails8     = tl;
        out_rdy    = rdy;
        credit_ret = ret;
        out_domain = dom;
        reset      = (rst_mode == 2) ? 1'b0 : 1'b1;
        if (rst_mode == 2) begin
            model_reset(0);
            model_reset(1);
        end
        if (rst_mode == 1) begin
            #2;
            reset = 1'b0;
            model_reset(0);
            model_reset(1);
        end
        sb_q0.push_back(model_expect(0));
        sb_q1.push_back(model_expect(1));
    endtask

    initial begin
        logic [7:0] rq;
        logic [7:0] tl;
        logic       rdy;
        logic       ret;
        logic       dom_v;
        int         mode;

        model_reset(0);
        model_reset(1);

        // Reset held: everything quiet even with all requests up.
        step(8'hFF, 8'hFF, 1, 1, 0, 2);
        step(8'hFF, 8'hFF, 1, 1, 0, 2);

        // Fairness: single-flit packets rotate 0,1,2,0.
        repeat (4) step(8'h07, 8'h07, 1, 1, 0, 0);

        // Wormhole: input 1 holds for a 3-flit packet, then input 2.
        step(8'h07, 8'h00, 1, 1, 0, 0);
        step(8'h07, 8'h00, 1, 1, 0, 0);
        step(8'h07, 8'h02, 1, 1, 0, 0);
        step(8'h07, 8'h07, 1, 1, 0, 0);

        // Locked stall: input 1 drops req mid-packet, input 0 must wait.
        step(8'h02, 8'h00, 1, 1, 0, 0);
        step(8'h01, 8'h00, 1, 1, 0, 0);
        step(8'h01, 8'h00, 1, 1, 0, 0);
        step(8'h03, 8'h02, 1, 1, 0, 0);
        step(8'h01, 8'h01, 1, 1, 0, 0);

        // Credits: two fires, then starve; one return buys one fire.
        repeat (4) step(8'h07, 8'h07, 1, 0, 0, 0);
        step(8'h07, 8'h07, 1, 1, 0, 0);
        repeat (3) step(8'h07, 8'h07, 1, 0, 0, 0);
        // Fire and return together leaves the count alone.
        step(8'h07, 8'h07, 1, 1, 0, 0);
        step(8'h07, 8'h07, 1, 1, 0, 0);
        step(8'h07, 8'h07, 1, 0, 0, 0);
        step(8'h07, 8'h07, 1, 0, 0, 0);
        repeat (2) step(8'h00, 8'h00, 0, 1, 0, 0);

        // Domain change in the middle of a packet from input 2.
        step(8'h04, 8'h00, 1, 1, 0, 0);
        step(8'h05, 8'h00, 1, 1, 1, 0);
        step(8'h05, 8'h05, 1, 1, 1, 0);
        step(8'h05, 8'h05, 1, 1, 1, 0);

        // Async reset while locked on input 1, then recovery.
        step(8'h02, 8'h00, 1, 1, 1, 0);
        step(8'h02, 8'h00, 1, 1, 1, 1);
        step(8'h07, 8'h07, 1, 1, 1, 2);
        repeat (4) step(8'h07, 8'h07, 1, 0, 1, 0);

        // Async reset while dut1 is locked on input 4.
        step(8'h10, 8'h00, 1, 1, 1, 0);
        step(8'h10, 8'h00, 1, 1, 1, 1);
        step(8'h1F, 8'h1F, 1, 1, 1, 0);
        step(8'h1F, 8'h1F, 1, 1, 1, 0);

        // Randomised traffic with occasional domain flips and reset pulses.
        dom_v = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rq   = 8'($urandom);
            tl   = 8'($urandom);
            rdy  = ($urandom_range(0, 9) != 0);
            ret  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) dom_v = ~dom_v;
            mode = ($urandom_range(0, 99) == 0) ? 1 : 0;
            step(rq, tl, rdy, ret, dom_v, mode);
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb_q0.size() != 0 || sb_q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0",
                     sb_q0.size(), sb_q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
